// File: rtl/countdown_timer_n.sv
// Editable BCD countdown timer: digits are set with a cursor, then counted down
// once per TICK_DIV clocks; reaching zero raises a one-cycle done and a blinking alarm.
module countdown_timer_n #(
   parameter int DIGITS    = 4,
   parameter int TICK_DIV  = 100000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  up,
   input  logic                  down,
   input  logic                  left,
   input  logic                  right,
   input  logic                  start,
   input  logic                  modify,
   output logic [4*DIGITS-1:0]   value,
   output logic [2:0]            cursor,
   output logic [1:0]            state,
   output logic                  done,
   output logic                  alarm
);

   localparam int VW = 4 * DIGITS;
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [2:0]    CUR_LAST   = 3'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_SET   = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [VW-1:0]   r_value;
   logic [VW-1:0]   r_preset;
   logic [2:0]      r_cursor;
   logic [PW-1:0]   r_presc;
   logic [BW-1:0]   r_blink;
   logic            r_done;
   logic            r_alarm;

   state_t          w_state_nxt;
   logic [VW-1:0]   w_value_nxt;
   logic [VW-1:0]   w_preset_nxt;
   logic [2:0]      w_cursor_nxt;
   logic [PW-1:0]   w_presc_nxt;
   logic [BW-1:0]   w_blink_nxt;
   logic            w_done_nxt;
   logic            w_alarm_nxt;

   logic [VW-1:0]   w_dec;
   logic            w_tick;
   logic            w_is_zero;

   // Whole-number decrement with borrow rippling through every BCD digit.
   function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
      logic [VW-1:0] res;
      logic          borrow;
      logic [3:0]    d;
      res    = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               res[4*i +: 4] = 4'd9;
            end else begin
               res[4*i +: 4] = d - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Single-digit modulo-10 step; neighbouring digits are never touched.
   function automatic logic [VW-1:0] edit_digit(input logic [VW-1:0] v,
                                                input logic [2:0]    cur,
                                                input logic          inc);
      logic [VW-1:0] res;
      logic [3:0]    d;
      res = v;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (i == int'(cur)) begin
            if (inc) res[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
            else     res[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
         end
      end
      return res;
   endfunction

   assign w_dec     = bcd_dec(r_value);
   assign w_tick    = (r_presc == PRESC_LAST);
   assign w_is_zero = (r_value == '0);

   always_comb begin
      w_state_nxt  = r_state;
      w_value_nxt  = r_value;
      w_preset_nxt = r_preset;
      w_cursor_nxt = r_cursor;
      w_presc_nxt  = r_presc;
      w_blink_nxt  = '0;
      w_done_nxt   = 1'b0;
      w_alarm_nxt  = 1'b0;

      case (r_state)
         S_SET: begin
            if (start && !w_is_zero) begin
               w_preset_nxt = r_value;
               w_presc_nxt  = '0;
               w_state_nxt  = S_RUN;
            end else begin
               if (up ^ down) w_value_nxt = edit_digit(r_value, r_cursor, up);
               if (left && !right)
                  w_cursor_nxt = (r_cursor == CUR_LAST) ? 3'd0 : r_cursor + 3'd1;
               else if (right && !left)
                  w_cursor_nxt = (r_cursor == 3'd0) ? CUR_LAST : r_cursor - 3'd1;
            end
         end
         S_RUN: begin
            // The pausing edge does not advance the prescaler, so resume continues from the same count.
            if (start) begin
               w_state_nxt = S_PAUSE;
            end else if (w_tick) begin
               w_presc_nxt = '0;
               w_value_nxt = w_dec;
               if (w_dec == '0) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_alarm_nxt = 1'b1;
               end
            end else begin
               w_presc_nxt = r_presc + PW'(1);
            end
         end
         S_PAUSE: begin
            if (start)       w_state_nxt = S_RUN;
            else if (modify) w_state_nxt = S_SET;
         end
         S_DONE: begin
            if (start) begin
               w_value_nxt = r_preset;
               w_presc_nxt = '0;
               w_state_nxt = S_RUN;
            end else if (modify) begin
               w_value_nxt = r_preset;
               w_state_nxt = S_SET;
            end else if (r_blink == BLINK_LAST) begin
               w_alarm_nxt = ~r_alarm;
            end else begin
               w_blink_nxt = r_blink + BW'(1);
               w_alarm_nxt = r_alarm;
            end
         end
         default: w_state_nxt = S_SET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_SET;
         r_value  <= '0;
         r_preset <= '0;
         r_cursor <= 3'd0;
         r_presc  <= '0;
         r_blink  <= '0;
         r_done   <= 1'b0;
         r_alarm  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_value  <= w_value_nxt;
         r_preset <= w_preset_nxt;
         r_cursor <= w_cursor_nxt;
         r_presc  <= w_presc_nxt;
         r_blink  <= w_blink_nxt;
         r_done   <= w_done_nxt;
         r_alarm  <= w_alarm_nxt;
      end
   end

   assign value  = r_value;
   assign cursor = r_cursor;
   assign state  = r_state;
   assign done   = r_done;
   assign alarm  = r_alarm;

endmodule

// File: tb/tb_countdown_timer_n.sv
// Directed bench for countdown_timer_n with DIGITS=4, TICK_DIV=4, BLINK_DIV=3:
// a vector table for editing plus hand sequences for run, pause, done and reset.
module tb_countdown_timer_n;

   localparam logic [5:0] NO = 6'b000000;
   localparam logic [5:0] UP = 6'b100000;
   localparam logic [5:0] DN = 6'b010000;
   localparam logic [5:0] LF = 6'b001000;
   localparam logic [5:0] RT = 6'b000100;
   localparam logic [5:0] ST = 6'b000010;
   localparam logic [5:0] MD = 6'b000001;

   logic        clk;
   logic        rst_n;
   logic        up, down, left, right, start, modify;
   logic [15:0] value;
   logic [2:0]  cursor;
   logic [1:0]  state;
   logic        done;
   logic        alarm;

   int checks = 0;
   int errors = 0;

   countdown_timer_n #(.DIGITS(4), .TICK_DIV(4), .BLINK_DIV(3)) dut (
      .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
      .start(start), .modify(modify), .value(value), .cursor(cursor),
      .state(state), .done(done), .alarm(alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [5:0]  in;
      logic [15:0] v;
      logic [2:0]  c;
      logic [1:0]  s;
   } vec_t;

   vec_t vt[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] in);
      {up, down, left, right, start, modify} = in;
      @(posedge clk);
      #1;
      {up, down, left, right, start, modify} = NO;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string name, input logic [15:0] v, input logic [1:0] s);
      check({name, "_value"}, 32'(value), 32'(v));
      check({name, "_state"}, 32'(state), 32'(s));
   endtask

   initial begin
      vt[0]  = '{ST,      16'h0000, 3'd0, 2'd0};
      vt[1]  = '{RT,      16'h0000, 3'd3, 2'd0};
      vt[2]  = '{LF,      16'h0000, 3'd0, 2'd0};
      vt[3]  = '{UP,      16'h0001, 3'd0, 2'd0};
      vt[4]  = '{UP,      16'h0002, 3'd0, 2'd0};
      vt[5]  = '{UP,      16'h0003, 3'd0, 2'd0};
      vt[6]  = '{LF,      16'h0003, 3'd1, 2'd0};
      vt[7]  = '{UP,      16'h0013, 3'd1, 2'd0};
      vt[8]  = '{DN,      16'h0003, 3'd1, 2'd0};
      vt[9]  = '{DN,      16'h0093, 3'd1, 2'd0};
      vt[10] = '{UP | DN, 16'h0093, 3'd1, 2'd0};
      vt[11] = '{LF | RT, 16'h0093, 3'd1, 2'd0};
      vt[12] = '{UP,      16'h0003, 3'd1, 2'd0};
      vt[13] = '{DN,      16'h0093, 3'd1, 2'd0};
      vt[14] = '{LF,      16'h0093, 3'd2, 2'd0};
      vt[15] = '{LF,      16'h0093, 3'd3, 2'd0};
      vt[16] = '{LF,      16'h0093, 3'd0, 2'd0};
      vt[17] = '{RT,      16'h0093, 3'd3, 2'd0};
      vt[18] = '{DN,      16'h9093, 3'd3, 2'd0};
      vt[19] = '{NO,      16'h9093, 3'd3, 2'd0};

      rst_n = 1'b0;
      {up, down, left, right, start, modify} = NO;
      idle(2);
      check_out("reset", 16'h0000, 2'd0);
      check("reset_cursor", 32'(cursor), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_alarm", 32'(alarm), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         drive(vt[i].in);
         check($sformatf("vec%0d_value", i), 32'(value), 32'(vt[i].v));
         check($sformatf("vec%0d_cursor", i), 32'(cursor), 32'(vt[i].c));
         check($sformatf("vec%0d_state", i), 32'(state), 32'(vt[i].s));
      end

      // Countdown from 0x0100: one step per 4 cycles, 100 steps to zero.
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      drive(LF);
      drive(LF);
      drive(UP);
      check_out("load100", 16'h0100, 2'd0);
      drive(ST);
      check_out("run_start", 16'h0100, 2'd1);
      idle(3);
      check_out("run_3", 16'h0100, 2'd1);
      idle(1);
      check_out("run_4", 16'h0099, 2'd1);
      idle(392);
      check_out("run_396", 16'h0001, 2'd1);
      idle(3);
      check_out("run_399", 16'h0001, 2'd1);
      check("run_399_done", 32'(done), 32'd0);
      idle(1);
      check_out("done_entry", 16'h0000, 2'd3);
      check("done_pulse", 32'(done), 32'd1);
      check("alarm_entry", 32'(alarm), 32'd1);
      for (int k = 1; k <= 9; k++) begin
         idle(1);
         check($sformatf("done_low_%0d", k), 32'(done), 32'd0);
         check($sformatf("alarm_%0d", k), 32'(alarm), ((k / 3) % 2 == 0) ? 32'd1 : 32'd0);
      end
      check("done_hold_state", 32'(state), 32'd3);

      // Modify from DONE restores the preset, then build 0x0005.
      drive(MD);
      check_out("done_modify", 16'h0100, 2'd0);
      check("done_modify_alarm", 32'(alarm), 32'd0);
      drive(DN);
      drive(RT);
      drive(RT);
      repeat (5) drive(UP);
      check_out("load5", 16'h0005, 2'd0);
      drive(ST);
      idle(19);
      check_out("run5_19", 16'h0001, 2'd1);
      idle(1);
      check_out("run5_done", 16'h0000, 2'd3);
      drive(ST);
      check_out("done_restart", 16'h0005, 2'd1);

      // Pause after two prescaler counts; resume must decrement two cycles later.
      idle(2);
      check_out("pre_pause", 16'h0005, 2'd1);
      drive(ST);
      check_out("paused", 16'h0005, 2'd2);
      drive(UP);
      idle(9);
      check_out("pause_hold", 16'h0005, 2'd2);
      drive(ST);
      check_out("resume", 16'h0005, 2'd1);
      idle(1);
      check_out("resume_1", 16'h0005, 2'd1);
      idle(1);
      check_out("resume_2", 16'h0004, 2'd1);

      drive(MD);
      check_out("run_modify_ignored", 16'h0004, 2'd1);
      drive(ST);
      drive(ST | MD);
      check_out("start_beats_modify", 16'h0004, 2'd1);
      drive(ST);
      drive(MD);
      check_out("pause_modify", 16'h0004, 2'd0);
      check("pause_modify_cursor", 32'(cursor), 32'd0);

      // Reset in the middle of a 0x0042 countdown, asserted together with start.
      drive(DN);
      drive(DN);
      drive(LF);
      repeat (4) drive(UP);
      check_out("load42", 16'h0042, 2'd0);
      drive(ST);
      idle(2);
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      check_out("rst_run", 16'h0000, 2'd0);
      check("rst_run_cursor", 32'(cursor), 32'd0);
      check("rst_run_done", 32'(done), 32'd0);
      check("rst_run_alarm", 32'(alarm), 32'd0);
      drive(ST);
      check_out("start_at_zero", 16'h0000, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
